// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin arbiter sharing one DMA core among N requesters
//
// Purpose: picks one requester at a time (round-robin from ptr), latches its
// descriptor, fires a one-cycle start pulse to the DMA core and holds the
// grant until the core reports completion or the watchdog expires.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[N]              request levels (0=conv, 1=pool, 2=usb)
//   req_addr/len/wr     per-requester descriptors, slice i = requester i
//   gnt[N]              one-hot grant, held for the whole transfer
//   done[N]             one-cycle completion pulse to the winner
//   dma_start           one-cycle start pulse to the DMA core
//   dma_addr/len/wr     latched descriptor, stable while granted
//   dma_done            completion pulse from the DMA core
//   err, err_id         watchdog pulse and sticky index of the timed-out requester
module dma_arbiter #(
  parameter int N       = 3,
  parameter int AW      = 32,
  parameter int LW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*LW-1:0] req_len,
  input  logic [N-1:0]    req_wr,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic            dma_start,
  output logic [AW-1:0]   dma_addr,
  output logic [LW-1:0]   dma_len,
  output logic            dma_wr,
  input  logic            dma_done,
  output logic            err,
  output logic [1:0]      err_id
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0] PLAST = PW'(N - 1);
  localparam logic [N-1:0]  ONE   = N'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [TW-1:0] timer;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [CW-1:0] cand;
  logic [AW-1:0] win_addr;
  logic [LW-1:0] win_len;
  logic          win_wr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PLAST) return '0;
    return p + PW'(1);
  endfunction

  // Scan ptr, ptr+1, ... mod N; cand is one bit wider so the sum cannot wrap
  // before the explicit mod-N correction.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    win_wr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) begin
        win_addr = req_addr[i*AW +: AW];
        win_len  = req_len[i*LW +: LW];
        win_wr   = req_wr[i];
      end
    end
  end

  // TLAST is only reachable when the watchdog is enabled.
  logic expire;
  assign expire = (TIMEOUT > 0) && (timer == TLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      timer     <= '0;
      gnt       <= '0;
      done      <= '0;
      dma_start <= 1'b0;
      dma_addr  <= '0;
      dma_len   <= '0;
      dma_wr    <= 1'b0;
      err       <= 1'b0;
      err_id    <= '0;
    end else begin
      done      <= '0;
      err       <= 1'b0;
      dma_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            if (win_len == '0) begin
              // Nothing to move: acknowledge straight away without the DMA core.
              done <= ONE << win_idx;
              ptr  <= next_ptr(win_idx);
            end else begin
              own       <= win_idx;
              gnt       <= ONE << win_idx;
              dma_start <= 1'b1;
              dma_addr  <= win_addr;
              dma_len   <= win_len;
              dma_wr    <= win_wr;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // dma_done here belongs to nobody and is ignored.
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (dma_done) begin
            // Completion beats a watchdog expiry in the same cycle.
            gnt   <= '0;
            done  <= ONE << own;
            ptr   <= next_ptr(own);
            timer <= '0;
            state <= IDLE;
          end else if (expire) begin
            gnt    <= '0;
            err    <= 1'b1;
            err_id <= 2'(own);
            ptr    <= next_ptr(own);
            timer  <= '0;
            state  <= IDLE;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb/tb_dma_arbiter.sv - self-checking bench for dma_arbiter
module tb_dma_arbiter;
  localparam int N       = 3;
  localparam int AW      = 32;
  localparam int LW      = 16;
  localparam int TIMEOUT = 16;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [N-1:0]    req      = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len  = '0;
  logic [N-1:0]    req_wr   = '0;
  logic            dma_done = 1'b0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            dma_start;
  logic [AW-1:0]   dma_addr;
  logic [LW-1:0]   dma_len;
  logic            dma_wr;
  logic            err;
  logic [1:0]      err_id;

  always #5 clk = ~clk;

  dma_arbiter #(.N(N), .AW(AW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
    .req_wr(req_wr), .gnt(gnt), .done(done), .dma_start(dma_start),
    .dma_addr(dma_addr), .dma_len(dma_len), .dma_wr(dma_wr), .dma_done(dma_done),
    .err(err), .err_id(err_id)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int order [4] = '{0, 1, 2, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic set_desc(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
    req_wr = (req_wr & ~(N'(1) << i)) | (N'(w) << i);
  endtask

  // Reference model: who owns the DMA, how long it has waited, whose turn is next.
  int            m_owner   = -1;
  bit            m_started = 1'b0;
  int            m_wait    = 0;
  int            m_ptr     = 0;
  int            m_w       = -1;
  logic [N-1:0]  e_gnt     = '0;
  logic [N-1:0]  e_done    = '0;
  logic          e_start   = 1'b0;
  logic          e_err     = 1'b0;
  logic [1:0]    e_err_id  = '0;
  logic [AW-1:0] e_addr    = '0;
  logic [LW-1:0] e_len     = '0;
  logic          e_wr      = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_started = 1'b0; m_wait = 0; m_ptr = 0;
      e_gnt = '0; e_done = '0; e_start = 1'b0; e_err = 1'b0; e_err_id = '0;
      e_addr = '0; e_len = '0; e_wr = 1'b0;
    end else begin
      cyc++;
      e_done  = '0;
      e_err   = 1'b0;
      e_start = 1'b0;
      if (m_owner < 0) begin
        m_w = -1;
        for (int k = 0; k < N; k++)
          if (m_w < 0 && bit_of(req, (m_ptr + k) % N)) m_w = (m_ptr + k) % N;
        if (m_w >= 0) begin
          if (LW'(req_len >> (m_w * LW)) == '0) begin
            e_done = N'(1) << m_w;
            m_ptr  = (m_w + 1) % N;
          end else begin
            m_owner   = m_w;
            m_started = 1'b0;
            m_wait    = 0;
            e_gnt     = N'(1) << m_w;
            e_start   = 1'b1;
            e_addr    = AW'(req_addr >> (m_w * AW));
            e_len     = LW'(req_len >> (m_w * LW));
            e_wr      = bit_of(req_wr, m_w);
          end
        end
      end else if (!m_started) begin
        m_started = 1'b1;
      end else begin
        m_wait++;
        if (dma_done || (TIMEOUT != 0 && m_wait == TIMEOUT)) begin
          if (dma_done) e_done = N'(1) << m_owner;
          else begin
            e_err    = 1'b1;
            e_err_id = 2'(m_owner);
          end
          e_gnt   = '0;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("gnt", gnt, e_gnt);
      check("done", done, e_done);
      check("dma_start", dma_start, e_start);
      check("err", err, e_err);
      check("err_id", err_id, e_err_id);
      if (e_gnt != '0) begin
        check("dma_addr", dma_addr, e_addr);
        check("dma_len", dma_len, e_len);
        check("dma_wr", dma_wr, e_wr);
      end
    end
  end

  task automatic wait_start(output int ok);
    ok = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (dma_start) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic int decode(input logic [N-1:0] g);
    if (g == 3'b001) return 0;
    if (g == 3'b010) return 1;
    if (g == 3'b100) return 2;
    return -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ok;
    int got;
    int t_prev;
    int dly;
    int k;
    dly = 0;
    t_prev = 0;

    repeat (2) tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_start", dma_start, 0);
    check("rst_err", err, 0);
    check("rst_err_id", err_id, 0);
    check("rst_addr", dma_addr, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // single transfer
    set_desc(0, 32'h100, 16'd8, 1'b0);
    req = 3'b001;
    tick();
    check("t1_gnt", gnt, 3'b001);
    check("t1_start", dma_start, 1);
    check("t1_addr", dma_addr, 32'h100);
    check("t1_len", dma_len, 8);
    tick();
    check("t1_start_low", dma_start, 0);
    repeat (4) tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("t1_done", done, 3'b001);
    check("t1_release", gnt, 0);
    req = '0;
    tick();

    // watchdog on requester 1
    set_desc(1, 32'h2000, 16'd4, 1'b1);
    req = 3'b010;
    tick();
    check("t3_gnt", gnt, 3'b010);
    tick();
    repeat (15) tick();
    check("t3_hold", gnt, 3'b010);
    check("t3_err_early", err, 0);
    tick();
    check("t3_err", err, 1);
    check("t3_err_id", err_id, 1);
    check("t3_gnt_off", gnt, 0);
    check("t3_no_done", done, 0);
    req = '0;
    tick();

    // zero length; req0 also set, so serving 2 shows ptr moved to 2
    set_desc(0, 32'h300, 16'd5, 1'b0);
    set_desc(2, 32'h400, 16'd0, 1'b1);
    req = 3'b101;
    tick();
    check("t4_done", done, 3'b100);
    check("t4_no_start", dma_start, 0);
    check("t4_gnt", gnt, 0);
    req = '0;
    tick();

    // fairness with all three held
    set_desc(0, 32'h1000, 16'd3, 1'b0);
    set_desc(1, 32'h1100, 16'd7, 1'b1);
    set_desc(2, 32'h1200, 16'd9, 1'b0);
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      check("t2_started", ok, 1);
      got = decode(gnt);
      check("t2_order", got, order[i]);
      if (i > 0) check("t2_gap", cyc - t_prev, 5);
      t_prev = cyc;
      repeat (3) tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      check("t2_done", done, N'(1) << order[i]);
    end
    req = '0;
    tick();

    // completion in the expiry cycle
    set_desc(0, 32'h500, 16'd12, 1'b1);
    req = 3'b001;
    tick();
    check("t6_gnt", gnt, 3'b001);
    repeat (16) tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("t6_done", done, 3'b001);
    check("t6_no_err", err, 0);
    req = '0;
    tick();

    // asynchronous reset mid-WAIT
    set_desc(0, 32'h600, 16'd20, 1'b0);
    req = 3'b001;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_gnt", gnt, 0);
    check("t5_start", dma_start, 0);
    check("t5_done", done, 0);
    check("t5_addr", dma_addr, 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    set_desc(1, 32'h700, 16'd2, 1'b1);
    req = 3'b010;
    tick();
    check("t5_regnt", gnt, 3'b010);
    check("t5_restart", dma_start, 1);
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("t5_redone", done, 3'b010);
    req = '0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      dma_done = 1'b0;
      if (err) dly = 0;
      else if (dly > 0) begin
        dly--;
        if (dly == 0) dma_done = 1'b1;
      end
      if (dma_start) begin
        k = $urandom_range(0, 20);
        if (k == 0) dma_done = 1'b1;
        else dly = k;
      end else if (gnt == '0 && dly == 0 && $urandom_range(0, 15) == 0) begin
        dma_done = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (bit_of(done, i) || (err && err_id == 2'(i))) begin
          req = req & ~(N'(1) << i);
        end else if (!bit_of(req, i) && $urandom_range(0, 3) == 0) begin
          set_desc(i, $urandom,
                   ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom_range(1, 300)),
                   1'($urandom_range(0, 1)));
          req = req | (N'(1) << i);
        end
      end
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
